// File: rtl/word_unpacker.sv
// Serialises one packed word of N elements (W bits each) into single-element beats,
// lowest index first, with a valid/ready handshake on both sides.
module word_unpacker #(
    parameter int unsigned N = 10,
    parameter int unsigned W = 10
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic [N*W-1:0]                       i_data,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic [W-1:0]                         o_data,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_index,
    output logic                                 o_last
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [IW-1:0] r_index;
    logic [IW-1:0] w_next_index;
    logic [W-1:0]  r_elem [N];
    logic [W-1:0]  w_elem;
    logic          w_load;
    logic          w_valid;
    logic          w_last;
    logic          w_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                r_elem[k] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            r_index <= w_next_index;
            if (w_load) begin
                for (int unsigned k = 0; k < N; k++) begin
                    r_elem[k] <= i_data[k*W +: W];
                end
            end
        end
    end

    always_comb begin
        w_elem = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (r_index == IW'(k)) begin
                w_elem = r_elem[k];
            end
        end
    end

    // In SEND, accepting the last beat frees the register that same cycle,
    // so o_ready follows i_ready combinationally to avoid an idle bubble.
    always_comb begin
        w_valid = (r_state == ST_SEND);
        w_last  = w_valid && (r_index == LAST_IDX);
        w_ready = (r_state == ST_IDLE) || (w_last && i_ready);
    end

    always_comb begin
        w_next_state = r_state;
        w_next_index = r_index;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_load       = 1'b1;
                    w_next_index = '0;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_ready) begin
                    if (!w_last) begin
                        w_next_index = r_index + 1'b1;
                    end else if (i_valid) begin
                        w_load       = 1'b1;
                        w_next_index = '0;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_index = '0;
            end
        endcase
    end

    assign o_valid = w_valid;
    assign o_ready = w_ready;
    assign o_last  = w_last;
    assign o_index = r_index;
    assign o_data  = w_elem;

endmodule

// File: tb/tb_word_unpacker.sv
// Randomised and directed checks of word_unpacker (N=10/W=10 and N=1/W=8)
// against queue-based reference models of the element stream.
module tb_word_unpacker;

    localparam int unsigned N  = 10;
    localparam int unsigned W  = 10;
    localparam int unsigned WB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           a_rst, a_valid, a_oready, a_ovalid, a_iready, a_last;
    logic [N*W-1:0] a_data;
    logic [W-1:0]   a_odata;
    logic [3:0]     a_index;

    logic          b_rst, b_valid, b_oready, b_ovalid, b_iready, b_last;
    logic [WB-1:0] b_data;
    logic [WB-1:0] b_odata;
    logic [0:0]    b_index;

    word_unpacker #(.N(N), .W(W)) u_dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_valid(a_valid), .o_ready(a_oready),
        .i_data(a_data), .o_valid(a_ovalid), .i_ready(a_iready),
        .o_data(a_odata), .o_index(a_index), .o_last(a_last)
    );

    word_unpacker #(.N(1), .W(WB)) u_dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_valid(b_valid), .o_ready(b_oready),
        .i_data(b_data), .o_valid(b_ovalid), .i_ready(b_iready),
        .o_data(b_odata), .o_index(b_index), .o_last(b_last)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Remaining elements of the word currently being emitted, front = on o_data
    logic [W-1:0]  qa[$];
    logic [WB-1:0] qb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] mkword(input int base, input int stride);
        logic [N*W-1:0] w;
        w = '0;
        for (int k = 0; k < int'(N); k++) w[k*W +: W] = W'(base + stride * k);
        return w;
    endfunction

    function automatic logic [N*W-1:0] rndword();
        logic [N*W-1:0] w;
        w = '0;
        for (int k = 0; k < int'(N); k++) w[k*W +: W] = W'($urandom);
        return w;
    endfunction

    // One cycle on DUT A: drive, check at negedge, advance the model at posedge.
    task automatic step_a(input logic rst, input logic v, input logic [N*W-1:0] d, input logic rdy);
        logic ev, er;
        a_rst = rst; a_valid = v; a_data = d; a_iready = rdy;
        @(negedge clk);
        ev = (qa.size() != 0);
        er = !ev || (qa.size() == 1 && rdy);
        check("a_o_valid", 32'(a_ovalid), 32'(ev));
        check("a_o_ready", 32'(a_oready), 32'(er));
        if (ev) begin
            check("a_o_data", 32'(a_odata), 32'(qa[0]));
            check("a_o_index", 32'(a_index), N - qa.size());
            check("a_o_last", 32'(a_last), 32'(qa.size() == 1));
        end else begin
            check("a_o_last_idle", 32'(a_last), 32'd0);
        end
        @(posedge clk);
        if (rst) begin
            qa.delete();
        end else begin
            if (ev && rdy) void'(qa.pop_front());
            if (v && er) for (int k = 0; k < int'(N); k++) qa.push_back(d[k*W +: W]);
        end
        #1;
    endtask

    task automatic idle_check_a(input string tag);
        a_rst = 1'b0; a_valid = 1'b0; a_iready = 1'b1;
        @(negedge clk);
        check({tag, "_valid"}, 32'(a_ovalid), 32'd0);
        check({tag, "_ready"}, 32'(a_oready), 32'd1);
        check({tag, "_index"}, 32'(a_index), 32'd0);
        check({tag, "_data"}, 32'(a_odata), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic rst, input logic v, input logic [WB-1:0] d, input logic rdy);
        logic ev, er;
        b_rst = rst; b_valid = v; b_data = d; b_iready = rdy;
        @(negedge clk);
        ev = (qb.size() != 0);
        er = !ev || rdy;
        check("b_o_valid", 32'(b_ovalid), 32'(ev));
        check("b_o_ready", 32'(b_oready), 32'(er));
        if (ev) begin
            check("b_o_data", 32'(b_odata), 32'(qb[0]));
            check("b_o_index", 32'(b_index), 32'd0);
            check("b_o_last", 32'(b_last), 32'd1);
        end
        @(posedge clk);
        if (rst) begin
            qb.delete();
        end else begin
            if (ev && rdy) void'(qb.pop_front());
            if (v && er) qb.push_back(d);
        end
        #1;
    endtask

    initial begin
        a_rst = 1'b1; a_valid = 1'b0; a_data = '0; a_iready = 1'b0;
        b_rst = 1'b1; b_valid = 1'b0; b_data = '0; b_iready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        b_rst = 1'b0;
        idle_check_a("rst");

        // Single word, full throughput
        step_a(1'b0, 1'b1, mkword(1, 1), 1'b1);
        repeat (11) step_a(1'b0, 1'b0, '0, 1'b1);

        // Backpressure: i_ready high one cycle in three
        step_a(1'b0, 1'b1, mkword(1, 1), 1'b1);
        for (int i = 0; i < 32; i++) step_a(1'b0, 1'b0, '0, (i % 3) == 0);

        // Back-to-back: second word waits on i_valid until the last beat
        step_a(1'b0, 1'b1, mkword(1, 1), 1'b1);
        repeat (10) step_a(1'b0, 1'b1, mkword(32'h3FF, -1), 1'b1);
        repeat (11) step_a(1'b0, 1'b0, '0, 1'b1);

        // Reset after element 4 accepted
        step_a(1'b0, 1'b1, mkword(1, 1), 1'b1);
        repeat (5) step_a(1'b0, 1'b0, '0, 1'b1);
        step_a(1'b1, 1'b0, '0, 1'b1);
        idle_check_a("midrst");
        repeat (10) step_a(1'b0, 1'b0, '0, 1'b1);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++)
            step_a($urandom_range(0, 150) == 0, $urandom_range(0, 1) == 1, rndword(),
                   $urandom_range(0, 3) != 0);
        step_a(1'b1, 1'b0, '0, 1'b1);

        // N=1 block: back-to-back single-beat words
        step_b(1'b0, 1'b1, 8'hA5, 1'b1);
        step_b(1'b0, 1'b1, 8'h5A, 1'b1);
        repeat (2) step_b(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 200; i++)
            step_b($urandom_range(0, 60) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
                   $urandom_range(0, 2) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/word_unpacker.md
Name: word_unpacker

Overview:
- Reader-side counterpart of the packed-array variable writer.
- Accepts one packed word of N elements, each W bits wide, over a valid/ready handshake.
- Emits the elements one per beat, lowest index first, over a second valid/ready handshake, and flags the final element.
- Sits between a block that produces 10x10 packed buffers and any element-serial consumer.

Parameters:
- N, 10, number of elements per packed word; N >= 1.
- W, 10, width of each element in bits; W >= 1.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  unpacker can accept a word this cycle.
- i_data  input  N*W  packed word; element k is i_data[k*W +: W].
- o_valid  output  1  element valid on o_data.
- i_ready  input  1  downstream accepts the element this cycle.
- o_data  output  W  current element.
- o_index  output  max(1,$clog2(N))  index of the current element.
- o_last  output  1  current element is index N-1.

Behaviour:
- Reset: i_rst high at a rising edge puts the block in IDLE, clears the index to 0 and clears the data register to 0.
- Reset outputs: o_valid=0, o_last=0, o_index=0, o_data=0. o_ready goes to 1 once in IDLE.
- Reset mid-operation: a word in flight is discarded and no further elements are emitted.
- Reset priority: reset wins over any simultaneous handshake.
- State IDLE:
  - o_valid=0, o_ready=1.
  - On i_valid && o_ready: capture i_data into the register, set index=0, go to SEND.
- State SEND:
  - o_valid=1.
  - o_data = register element[index]; o_index = index; o_last = (index == N-1).
- Beat accepted when o_valid && i_ready:
  - If index < N-1: index increments, state stays SEND.
  - If index == N-1 and no new word is captured the same cycle: go to IDLE.
- Back-to-back words:
  - In SEND, o_ready = o_last && i_ready. This combinational path from i_ready is intentional.
  - If that last-beat handshake and i_valid coincide, the new word is captured, index resets to 0 and the state stays SEND.
  - There is no idle bubble between words.
- Latency: first element is valid one cycle after the input handshake.
- Throughput: one element per cycle when i_ready is held high; a word takes N cycles.
- Backpressure: while o_valid && !i_ready, o_data, o_index and o_last hold stable.
- Valid rules:
  - o_valid never drops without an accepted beat, except on reset.
  - i_data is only sampled on an input handshake; changes at other times are ignored.
- N=1: every element is last; each word produces exactly one beat; back-to-back rule still applies.
- Index counter:
  - Wraps only by explicit reset to 0; it never counts past N-1.
  - Counter width is max(1,$clog2(N)) so N=1 and N=2 remain legal.
- No data reordering, masking or arithmetic on elements.

Test Plan:
- Reset then idle: hold i_rst 2 cycles, release -> o_valid=0, o_ready=1, o_index=0, o_data=0.
- Single word, full throughput: i_data element k = k+1 (values 1..10), i_ready=1.
  - Next 10 cycles show o_data 1,2,...,10 with o_index 0..9.
  - o_last=1 only with o_data=10; afterwards o_valid=0 and o_ready=1.
- Backpressure: same word, i_ready toggled 1,0,0,1,...
  - Every element appears exactly once, in order.
  - o_data, o_index and o_last are stable during the low cycles.
  - o_ready=0 until the last beat is accepted.
- Back-to-back: second word with elements 0x3FF..0x3F6 presented with i_valid during the last beat of the first word.
  - o_data=10 is followed immediately by 0x3FF at index 0, with no o_valid gap.
- Mid-word reset: assert i_rst after element index 4 is accepted -> next cycle o_valid=0 and o_index=0; no remaining elements appear.
- N=1, W=8: words 0xA5 then 0x5A with i_ready=1 -> each is emitted as one beat with o_last=1 and o_index=0, one word per cycle when back-to-back.
